// File: rtl/calc_phase_acc.sv
// Per-operator phase accumulator: a 36-entry accumulator memory, cleared by a sweep after reset.
// Two-cycle latency from p0 slot to phase_p2. No backpressure: one slot is accepted per cycle.
module calc_phase_acc #(
  parameter int NUM_BANKS      = 2,
  parameter int NUM_OPS        = 18,
  parameter int ACC_WIDTH      = 19,
  parameter int PHASE_WIDTH    = 10,
  parameter int BANK_NUM_WIDTH = $clog2(NUM_BANKS),
  parameter int OP_NUM_WIDTH   = $clog2(NUM_OPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_clk_en,
  input  logic [BANK_NUM_WIDTH-1:0] bank_num,
  input  logic [OP_NUM_WIDTH-1:0]   op_num,
  input  logic [9:0]                fnum,
  input  logic [2:0]                block,
  input  logic [3:0]                mult,
  input  logic                      vib,
  input  logic                      dvb,
  input  logic [2:0]                vib_pos,
  input  logic                      pg_reset,
  output logic [PHASE_WIDTH-1:0]    phase_p2,
  output logic                      init_busy
);

  localparam int NUM_SLOTS = NUM_BANKS * NUM_OPS;
  localparam int IDX_WIDTH = $clog2(NUM_SLOTS);

  typedef enum logic {INIT, RUN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   sweep_q, sweep_d;
  logic                   en_p1_q, en_p1_d;
  logic [IDX_WIDTH-1:0]   idx_p1_q, idx_p1_d;
  logic                   pg_reset_p1_q, pg_reset_p1_d;
  logic [ACC_WIDTH-1:0]   acc_p1_q, acc_p1_d;
  logic [ACC_WIDTH-1:0]   inc_p1_q, inc_p1_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;

  logic [ACC_WIDTH-1:0]   acc_mem [NUM_SLOTS];

  logic                   wr_en;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic [ACC_WIDTH-1:0]   wr_dat;

  logic                   slot_ok;
  logic [IDX_WIDTH-1:0]   idx_p0;
  logic [IDX_WIDTH-1:0]   rd_idx;

  logic [2:0]             vib_rng;
  logic [10:0]            f_vib;
  logic [17:0]            f_shifted;
  logic [16:0]            base;
  logic [4:0]             mt;
  logic [21:0]            prod;

  // Init sweep and run-state control.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == IDX_WIDTH'(NUM_SLOTS - 1)) begin
        state_d = RUN;
        sweep_d = '0;
      end
    end
  end

  // Single write port shared by the clear sweep and slot updates.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_dat = '0;
    if (state_q == INIT) begin
      wr_en  = 1'b1;
      wr_idx = sweep_q;
    end else if (en_p1_q) begin
      wr_en  = 1'b1;
      wr_idx = idx_p1_q;
      wr_dat = (pg_reset_p1_q ? '0 : acc_p1_q) + inc_p1_q;
    end
  end

  always_comb begin
    slot_ok = (32'(op_num) < NUM_OPS);
    idx_p0  = IDX_WIDTH'(bank_num) * IDX_WIDTH'(NUM_OPS) + IDX_WIDTH'(op_num);
    rd_idx  = slot_ok ? idx_p0 : '0;
  end

  always_comb begin
    vib_rng = fnum[9:7];
    if (vib_pos[1:0] == 2'd0) begin
      vib_rng = 3'd0;
    end else if (vib_pos[0]) begin
      vib_rng = vib_rng >> 1;
    end
    if (!dvb) begin
      vib_rng = vib_rng >> 1;
    end

    f_vib = {1'b0, fnum};
    if (vib) begin
      f_vib = vib_pos[2] ? ({1'b0, fnum} - 11'(vib_rng)) : ({1'b0, fnum} + 11'(vib_rng));
    end

    f_shifted = 18'(f_vib) << block;
    base      = f_shifted[17:1];

    case (mult)
      4'd0:    mt = 5'd1;
      4'd1:    mt = 5'd2;
      4'd2:    mt = 5'd4;
      4'd3:    mt = 5'd6;
      4'd4:    mt = 5'd8;
      4'd5:    mt = 5'd10;
      4'd6:    mt = 5'd12;
      4'd7:    mt = 5'd14;
      4'd8:    mt = 5'd16;
      4'd9:    mt = 5'd18;
      4'd10:   mt = 5'd20;
      4'd11:   mt = 5'd20;
      4'd12:   mt = 5'd24;
      4'd13:   mt = 5'd24;
      default: mt = 5'd30;
    endcase

    prod = 22'(base) * 22'(mt);
  end

  // A write to the slot being read this cycle is forwarded so back-to-back visits never see stale data.
  always_comb begin
    en_p1_d       = sample_clk_en && slot_ok && (state_q == RUN);
    idx_p1_d      = rd_idx;
    pg_reset_p1_d = pg_reset;
    inc_p1_d      = ACC_WIDTH'(prod >> 1);
    acc_p1_d      = (wr_en && (wr_idx == rd_idx)) ? wr_dat : acc_mem[rd_idx];
    phase_d       = phase_q;
    if (en_p1_q) begin
      phase_d = acc_p1_q[ACC_WIDTH-1 -: PHASE_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      sweep_q       <= '0;
      en_p1_q       <= 1'b0;
      idx_p1_q      <= '0;
      pg_reset_p1_q <= 1'b0;
      acc_p1_q      <= '0;
      inc_p1_q      <= '0;
      phase_q       <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      en_p1_q       <= en_p1_d;
      idx_p1_q      <= idx_p1_d;
      pg_reset_p1_q <= pg_reset_p1_d;
      acc_p1_q      <= acc_p1_d;
      inc_p1_q      <= inc_p1_d;
      phase_q       <= phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      acc_mem[wr_idx] <= wr_dat;
    end
  end

  assign phase_p2  = phase_q;
  assign init_busy = (state_q == INIT);

endmodule

// File: tb/tb_calc_phase_acc.sv
// Scoreboarded bench for calc_phase_acc: stimulus pushes expected phases, a monitor pops and compares.
module tb_calc_phase_acc;

  logic       clk;
  logic       rst_n;
  logic       sample_clk_en;
  logic [0:0] bank_num;
  logic [4:0] op_num;
  logic [9:0] fnum;
  logic [2:0] block;
  logic [3:0] mult;
  logic       vib;
  logic       dvb;
  logic [2:0] vib_pos;
  logic       pg_reset;
  logic [9:0] phase_p2;
  logic       init_busy;

  calc_phase_acc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_clk_en (sample_clk_en),
    .bank_num      (bank_num),
    .op_num        (op_num),
    .fnum          (fnum),
    .block         (block),
    .mult          (mult),
    .vib           (vib),
    .dvb           (dvb),
    .vib_pos       (vib_pos),
    .pg_reset      (pg_reset),
    .phase_p2      (phase_p2),
    .init_busy     (init_busy)
  );

  typedef struct {
    int due;
    int ph;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   model_acc [36];
  int   last_phase = 0;
  int   mt_tab [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
  int   fn_tab [36];
  int   blk_tab [36];
  int   ml_tab [36];
  int   vib_tab [36];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Monitor: phase_p2 is due two cycles after the slot was presented.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (int'(phase_p2) != e.ph) begin
          errors++;
          $display("FAIL phase_p2 tag=%0d cyc=%0d got %0d required %0d", e.tag, cyc, phase_p2, e.ph);
        end
      end
    end
  end

  function automatic int model_inc(int fn, int blk, int ml, int v, int d, int vp);
    int r;
    int f;
    int base;
    r = fn / 128;
    if (vp % 4 == 0) r = 0;
    else if (vp % 2 == 1) r = r / 2;
    if (d == 0) r = r / 2;
    if (vp >= 4) r = -r;
    f = fn + ((v != 0) ? r : 0);
    base = (f * (1 << blk)) / 2;
    return ((base * mt_tab[ml]) / 2) % 524288;
  endfunction

  // Drive one p0 slot now, record its expected output, then advance to the next negedge.
  task automatic issue(input int en, input int bank, input int op, input int fn, input int blk,
                       input int ml, input int v, input int d, input int vp, input int pg,
                       input int tag, input bit in_init);
    exp_t e;
    int   idx;
    sample_clk_en = (en != 0);
    bank_num      = 1'(bank);
    op_num        = 5'(op);
    fnum          = 10'(fn);
    block         = 3'(blk);
    mult          = 4'(ml);
    vib           = (v != 0);
    dvb           = (d != 0);
    vib_pos       = 3'(vp);
    pg_reset      = (pg != 0);
    e.due = cyc + 2;
    e.tag = tag;
    if (!in_init && en != 0 && op < 18) begin
      idx = bank * 18 + op;
      e.ph = model_acc[idx] / 512;
      model_acc[idx] = (((pg != 0) ? 0 : model_acc[idx]) + model_inc(fn, blk, ml, v, d, vp)) % 524288;
      last_phase = e.ph;
    end else begin
      e.ph = last_phase;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    sample_clk_en = 1'b0;
    pg_reset      = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_and_init();
    int cnt;
    sample_clk_en = 1'b0;
    pg_reset      = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 2;
    if (phase_p2 != 10'd0) begin
      errors++;
      $display("FAIL reset_phase got %0d required 0", phase_p2);
    end
    if (init_busy != 1'b1) begin
      errors++;
      $display("FAIL reset_busy got %0d required 1", init_busy);
    end
    foreach (model_acc[i]) model_acc[i] = 0;
    last_phase = 0;
    rst_n = 1'b1;
    cnt = 0;
    // Slots offered while the sweep runs must be ignored.
    while (init_busy && cnt < 100) begin
      cnt++;
      issue(1, $urandom_range(0, 1), $urandom_range(0, 17), $urandom_range(0, 1023),
            $urandom_range(0, 7), $urandom_range(0, 15), 1, 1, 2, 0, 0, 1'b1);
    end
    vectors++;
    if (cnt != 36) begin
      errors++;
      $display("FAIL init_busy_cycles got %0d required 36", cnt);
    end
  endtask

  task automatic random_sweeps(input int n, input int tag);
    int gate;
    int d;
    int vp;
    for (int s = 0; s < n; s++) begin
      gate = ($urandom_range(0, 3) != 0) ? 1 : 0;
      d    = $urandom_range(0, 1);
      vp   = $urandom_range(0, 7);
      for (int i = 0; i < 36; i++) begin
        issue(gate, i / 18, i % 18, fn_tab[i], blk_tab[i], ml_tab[i], vib_tab[i], d, vp,
              ($urandom_range(0, 7) == 0) ? 1 : 0, tag, 1'b0);
        if ($urandom_range(0, 9) == 0) begin
          issue(1, $urandom_range(0, 1), $urandom_range(18, 31), $urandom_range(0, 1023),
                7, 15, 0, 0, 0, 0, tag + 1, 1'b0);
        end
      end
    end
  endtask

  initial begin
    int vp_cases [6] = '{2, 1, 6, 0, 4, 2};
    int dvb_cases [6] = '{1, 1, 1, 1, 1, 0};
    sample_clk_en = 1'b0;
    bank_num = '0;
    op_num   = '0;
    fnum     = '0;
    block    = '0;
    mult     = '0;
    vib      = 1'b0;
    dvb      = 1'b0;
    vib_pos  = '0;
    pg_reset = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);

    reset_and_init();

    // Basic step on slot 0 with all other slots idle at fnum 0; phase reset on the 11th visit.
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < 36; i++) begin
        if (i == 0) issue(1, 0, 0, 512, 4, 1, 0, 0, 0, (s == 10) ? 1 : 0, 1, 1'b0);
        else        issue(1, i / 18, i % 18, 0, 0, 0, 0, 0, 0, 0, 2, 1'b0);
      end
    end

    // Same slot in consecutive cycles exercises write-to-read forwarding.
    for (int k = 0; k < 5; k++) issue(1, 0, 0, 512, 4, 1, 0, 0, 0, 0, 3, 1'b0);

    // Vibrato cases on bank0 op7: restart the phase, then observe inc>>9.
    for (int c = 0; c < 6; c++) begin
      issue(1, 0, 7, 'h380, 7, 15, 1, dvb_cases[c], vp_cases[c], 1, 4, 1'b0);
      issue(1, 0, 7, 'h380, 7, 15, 1, dvb_cases[c], vp_cases[c], 0, 5, 1'b0);
    end

    // Wrap-around on bank1 op2.
    issue(1, 1, 2, 1023, 7, 15, 0, 0, 0, 1, 6, 1'b0);
    for (int k = 0; k < 7; k++) begin
      issue(1, 1, 2, 1023, 7, 15, 0, 0, 0, 0, 7, 1'b0);
      issue(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8, 1'b0);
    end

    for (int i = 0; i < 36; i++) begin
      fn_tab[i]  = i * 28 + $urandom_range(0, 27);
      blk_tab[i] = $urandom_range(0, 7);
      ml_tab[i]  = $urandom_range(0, 15);
      vib_tab[i] = $urandom_range(0, 1);
    end
    random_sweeps(10, 10);

    drain();
    reset_and_init();
    random_sweeps(3, 20);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/calc_phase_acc.md
Name: calc_phase_acc

Overview:
- Per-operator phase generator. Each operator slot advances a stored 19-bit phase accumulator by an increment derived from fnum, block, mult and vibrato.
- Emits the 10-bit phase consumed by the rhythm-phase stage and the waveform lookup.
- Drives `phase_p2`, the producer end of that interface, aligned to the bank_num/op_num/sample_clk_en stream two cycles after p0.
- Accumulators live in a 36-entry memory. After reset, an init sweep clears them.

Parameters:
- NUM_BANKS, 2, number of banks.
- NUM_OPS, 18, operators per bank.
- ACC_WIDTH, 19, accumulator width.
- PHASE_WIDTH, 10, output phase width (= PHASE_FINAL_WIDTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_clk_en  in  1  p0 slot-valid strobe, one per operator slot
- bank_num  in  BANK_NUM_WIDTH  p0 bank of current slot
- op_num  in  OP_NUM_WIDTH  p0 operator of current slot
- fnum  in  10  p0 channel F-number
- block  in  3  p0 octave
- mult  in  4  p0 multiplier index
- vib  in  1  p0 vibrato enable for this operator
- dvb  in  1  p0 deep vibrato (global)
- vib_pos  in  3  p0 vibrato LFO position (global)
- pg_reset  in  1  p0 phase reset (key-on edge) for this slot
- phase_p2  out  PHASE_WIDTH  phase for slot presented at p0, valid at p2
- init_busy  out  1  high while the post-reset clear sweep runs

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-low.
- Reset: all pipeline registers cleared, phase_p2=0, init_busy=1, sweep counter=0. The accumulator memory is not reset asynchronously.

Init FSM:
- States are INIT and RUN.
- INIT writes 0 to entry 0..35, one per cycle, then enters RUN. That is 36 cycles, init_busy=1 throughout.
- During INIT, slot updates are ignored and phase_p2 holds 0.
- rst_n asserted mid-sweep or mid-run restarts INIT from entry 0.

Addressing:
- idx = bank_num*NUM_OPS + op_num.
- Out-of-range op_num (≥18) performs no write, and phase_p2 is unchanged.

Pipeline, p0 → p1:
- Registered memory read of acc[idx].
- Increment computed and registered.
- sample_clk_en, idx and pg_reset are delayed alongside.

Increment arithmetic, unsigned except where signed is stated:
- range = fnum[9:7].
- range = 0 if vib_pos[1:0]==0; otherwise range = range>>1 if vib_pos[0].
- range = range>>1 if dvb==0.
- range is negated if vib_pos[2].
- f = fnum + (vib ? range : 0), evaluated as 11-bit signed then treated as non-negative (fnum ≥ 0, |range| ≤ 7).
- base = (f << block) >> 1, 17 bits.
- inc = (base * MT[mult]) >> 1, truncated to ACC_WIDTH.
- MT = {1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30}.

p1 → p2, only when sample_clk_en_p1 and state==RUN:
- phase_p2 <= acc_old[18:9], i.e. the pre-update value.
- Write acc[idx] <= (pg_reset_p1 ? 0 : acc_old) + inc, modulo 2^19.
- When sample_clk_en_p1=0, phase_p2 holds and no write occurs.

Latency and forwarding:
- phase_p2 reflects the slot presented 2 cycles earlier.
- Read-during-write to the same idx in adjacent cycles forwards the newly written value, so no stale read.

Simultaneous events:
- pg_reset with vibrato: vibrato still applies to inc.
- Reset takes priority over everything.

Test Plan:
- Reset and init: hold rst_n=0 for 3 cycles, release → init_busy=1 for exactly 36 cycles then 0; phase_p2=0 throughout; the first slot update after init outputs phase 0.
- Basic step: bank0 op0, fnum=0x200, block=4, mult=1, vib=0; run consecutive samples → inc=4096; the sample-n output is 8*(n-1); other slots' outputs stay 0.
- Vibrato: fnum=0x380, vib=1, dvb=1, block=1, mult=1 → f is 0x387 (vib_pos=2), 0x37C+? no: 0x383 (vib_pos=1), 0x379 (vib_pos=6), 0x380 (vib_pos=0 or 4); with dvb=0 and vib_pos=2, f is 0x383. Check inc = f*2>>1 >>... per formula each case.
- Phase reset: accumulate to acc=40960, then assert pg_reset → that slot still outputs 80; the next sample outputs inc>>9 (8 for the basic-step settings).
- Wrap-around: fnum=1023, block=7, mult=15 → inc=457792 (982080 mod 2^19); outputs follow the acc sequence modulo 2^19.
- Independence and gating: all 36 slots with distinct fnum; sample_clk_en low for a whole sample → no accumulator change and phase_p2 holds. Assert rst_n mid-run → INIT restarts and all accumulators read 0 afterward.
